shift_sequencer: RTL and testbench

- Multi-cycle shift unit controller for the unpipelined processor datapath. It executes SLL/SRL/SRA/ROL one bit position per clock.
- Replaces a wide combinational barrel shifter for the R-type shift instructions.
- Takes a start request from the main control FSM, sequences the single-bit shift datapath for shamt cycles, then returns the result with a done pulse.
- Sits beside the ALU, ahead of the register-file write-back mux.

---
 rtl/shift_sequencer.sv | 138 +++++++++++++
 tb/tb_shift_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift unit controller for the unpipelined datapath. It replaces a
// wide combinational barrel shifter for the R-type shifts (SLL/SRL/SRA/ROL).
// The operand is moved one bit position per clock, so a shift by shamt takes
// shamt SHIFT cycles. A single-cycle done pulse then reports the result.
//
// Parameters:
//   WIDTH    data path width in bits
//   SHAMT_W  shift amount width (2**SHAMT_W == WIDTH)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   shift request, sampled only in IDLE or DONE
//   op       in   00 SLL, 01 SRL (zero fill), 10 SRA (sign fill), 11 ROL
//   data_in  in   operand (rt value)
//   shamt    in   shift amount
//   busy     out  high while shifting
//   done     out  one-cycle pulse, result valid
//   result   out  shifted value; held from done until the next accepted start
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    // Encoding 2'b11 is unused and recovers to IDLE through the default arm.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    state_t             state_q;
    op_t                op_q;
    logic [SHAMT_W-1:0] count_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   result_d;
    logic [SHAMT_W-1:0] count_d;

    // One-bit step of the latched operation, applied once per SHIFT cycle.
    always_comb begin
        result_d = result_q;
        case (op_q)
            OP_SLL: result_d = {result_q[WIDTH-2:0], 1'b0};
            OP_SRL: result_d = {1'b0, result_q[WIDTH-1:1]};
            OP_SRA: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            OP_ROL: result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
        endcase
        count_d = count_q - SHAMT_W'(1);
    end

    // Controller. busy/done are registered alongside the state so that they
    // are exactly (state==SHIFT) and (state==DONE) without output decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_SLL;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                // DONE accepts a new request exactly like IDLE, which allows
                // back-to-back shifts without an idle gap.
                IDLE, DONE: begin
                    if (start) begin
                        result_q <= data_in;
                        op_q     <= op_t'(op);
                        count_q  <= shamt;
                        if (shamt == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end

                // start is deliberately ignored here; requests are not queued.
                SHIFT: begin
                    result_q <= result_d;
                    count_q  <= count_d;
                    if (count_q == SHAMT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed bench for shift_sequencer. A behavioural model computes each final
// result with plain shift arithmetic and tracks how many shift cycles remain;
// a negedge process compares busy/done/result against it every cycle. The
// directed sequence additionally pins results and latencies to hand-computed
// literals.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dataIn;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int nChecks = 0;
    int nFails  = 0;

    // Model state
    int          mLeft     = 0;
    bit          mDone     = 0;
    logic [31:0] mRes      = '0;
    logic [31:0] mFinal    = '0;
    bit          mResValid = 0;
    bit          mArmed    = 0;

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .data_in (dataIn),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Whole-word result of a shift, independent of how the hardware steps.
    function automatic logic [31:0] modelShift(input logic [1:0] o,
                                               input logic [31:0] d,
                                               input logic [4:0] s);
        int sh;
        sh = int'(s);
        case (o)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: return (sh == 0) ? d : ((d << sh) | (d >> (32 - sh)));
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Model update: samples the same inputs the DUT sees at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mLeft     = 0;
            mDone     = 0;
            mRes      = '0;
            mResValid = 1;
            mArmed    = 1;
        end else if (mLeft == 0 && start) begin
            mFinal = modelShift(op, dataIn, shamt);
            if (shamt == 5'd0) begin
                mDone     = 1;
                mRes      = mFinal;
                mResValid = 1;
            end else begin
                mLeft     = int'(shamt);
                mDone     = 0;
                mResValid = 0;
            end
        end else if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 0) begin
                mDone     = 1;
                mRes      = mFinal;
                mResValid = 1;
            end
        end else begin
            mDone = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (mArmed) begin
            checkOutput("busy", {31'd0, busy}, {31'd0, (mLeft > 0)});
            checkOutput("done", {31'd0, done}, {31'd0, mDone});
            if (mResValid)
                checkOutput("result", result, mRes);
        end
    end

    // Issue one shift and wait for its done pulse. With backToBack set the
    // caller is mid-way through a DONE cycle, so start is raised immediately.
    // pokeAt > 0 raises a stray start for one cycle at that many cycles in.
    task automatic applyStimulus(input string name, input logic [1:0] o,
                                 input logic [31:0] d, input logic [4:0] s,
                                 input logic [31:0] expRes, input int expLat,
                                 input bit backToBack, input int pokeAt);
        int lat;
        bit found;
        lat   = 0;
        found = 0;
        if (!backToBack) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        op     = o;
        dataIn = d;
        shamt  = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (pokeAt > 0 && i == pokeAt + 1) start = 1'b0;
            if (done) begin
                lat   = i;
                found = 1;
                break;
            end
            if (pokeAt > 0 && i == pokeAt) begin
                start  = 1'b1;
                op     = 2'b00;
                dataIn = 32'hFFFF_FFFF;
                shamt  = 5'd1;
            end
        end
        start = 1'b0;
        checkOutput({name, "_doneSeen"}, {31'd0, found}, 32'd1);
        if (found) begin
            checkOutput({name, "_latency"}, lat, expLat);
            checkOutput({name, "_result"}, result, expRes);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        dataIn = '0;
        shamt  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        repeat (3) @(negedge clk);
        checkOutput("idleBusy", {31'd0, busy}, 32'd0);
        checkOutput("idleDone", {31'd0, done}, 32'd0);
        checkOutput("idleResult", result, 32'h0000_0000);

        applyStimulus("sll2",  2'b00, 32'h01C7_1C71, 5'd2,  32'h071C_71C4, 3,  0, 0);
        applyStimulus("sra4",  2'b10, 32'h8000_0010, 5'd4,  32'hF800_0001, 5,  0, 0);
        @(negedge clk);
        checkOutput("sra4_donePulseWidth", {31'd0, done}, 32'd0);
        applyStimulus("srl4",  2'b01, 32'h8000_0010, 5'd4,  32'h0800_0001, 5,  0, 0);
        @(negedge clk);
        checkOutput("srl4_donePulseWidth", {31'd0, done}, 32'd0);
        applyStimulus("rol0",  2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  0, 0);
        applyStimulus("rol31", 2'b11, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 0, 5);
        applyStimulus("b2bSll1", 2'b00, 32'h0000_000F, 5'd1, 32'h0000_001E, 2, 1, 0);

        // No further done pulses once the queue of work is empty.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("noExtraDone", {31'd0, done}, 32'd0);
        end

        // Reset in the 3rd SHIFT cycle of an SLL by 10.
        @(posedge clk);
        #1;
        start  = 1'b1;
        op     = 2'b00;
        dataIn = 32'h0000_0003;
        shamt  = 5'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("preRstBusy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstResult", result, 32'h0000_0000);

        applyStimulus("afterRstSra3", 2'b10, 32'h1234_5678, 5'd3, 32'h0246_8ACF, 4, 0, 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
